axis_packet_fifo: RTL and testbench

// Single-clock store-and-forward AXI-Stream FIFO. It sits directly upstream of the clock-crossing FIFO.
// It accumulates whole packets (terminated by tlast) and presents a packet downstream only once its last beat is stored.

---
 rtl/axis_packet_fifo.sv | 87 ++++++++
 tb/tb_axis_packet_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream FIFO: a packet is offered downstream only once its
// tlast beat is stored, except when an oversize packet fills the FIFO (cut-through).
module axis_packet_fifo #(
  parameter int DWIDTH     = 32,
  parameter int TKEEPWIDTH = 4,
  parameter int TSTRBWIDTH = 4,
  parameter int TIDWIDTH   = 8,
  parameter int TDESTWIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DWIDTH-1:0]     s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [TKEEPWIDTH-1:0] s_tkeep,
  input  logic [TSTRBWIDTH-1:0] s_tstrb,
  input  logic                  s_tuser,
  input  logic [TIDWIDTH-1:0]   s_tid,
  input  logic [TDESTWIDTH-1:0] s_tdest,
  output logic [DWIDTH-1:0]     m_tdata,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [TKEEPWIDTH-1:0] m_tkeep,
  output logic [TSTRBWIDTH-1:0] m_tstrb,
  output logic                  m_tuser,
  output logic [TIDWIDTH-1:0]   m_tid,
  output logic [TDESTWIDTH-1:0] m_tdest,
  output logic [AW:0]           count,
  output logic [AW:0]           pkt_count
);

  localparam int EW = DWIDTH + 1 + TKEEPWIDTH + TSTRBWIDTH + 1 + TIDWIDTH + TDESTWIDTH;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          cut_through;
  logic          wr;
  logic          rd;
  logic          wr_last;
  logic          rd_last;

  // Ready depends only on stored state, never on the downstream side.
  assign s_tready = ~areset & (count != FULL);
  assign wr       = s_tvalid & s_tready;
  assign wr_last  = wr & s_tlast;

  assign {m_tdata, m_tlast, m_tkeep, m_tstrb, m_tuser, m_tid, m_tdest} = mem[rd_ptr];
  assign m_tvalid = (count != '0) & ((pkt_count != '0) | cut_through);
  assign rd       = m_tvalid & m_tready;
  assign rd_last  = rd & m_tlast;

  always_ff @(posedge aclk) begin
    if (wr) mem[wr_ptr] <= {s_tdata, s_tlast, s_tkeep, s_tstrb, s_tuser, s_tid, s_tdest};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pkt_count   <= '0;
      cut_through <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;

      if (wr && !rd)      count <= count + CNT_ONE;
      else if (!wr && rd) count <= count - CNT_ONE;

      if (wr_last && !rd_last)      pkt_count <= pkt_count + CNT_ONE;
      else if (!wr_last && rd_last) pkt_count <= pkt_count - CNT_ONE;

      // A full FIFO holding no complete packet would deadlock; stream the partial one out.
      if (rd_last)                               cut_through <= 1'b0;
      else if (count == FULL && pkt_count == '0) cut_through <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench for axis_packet_fifo: stimulus pushes expected beats into a queue,
// an independent output monitor pops and compares every accepted output beat.
module tb_axis_packet_fifo;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [3:0]  s_tkeep = '0;
  logic [3:0]  s_tstrb = '0;
  logic        s_tuser = 1'b0;
  logic [7:0]  s_tid = '0;
  logic [7:0]  s_tdest = '0;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [3:0]  m_tkeep;
  logic [3:0]  m_tstrb;
  logic        m_tuser;
  logic [7:0]  m_tid;
  logic [7:0]  m_tdest;
  logic [4:0]  count;
  logic [4:0]  pkt_count;

  int n_cmp = 0;
  int n_fail = 0;
  logic [57:0] sb [$];
  logic [4:0]  max_count = '0;
  logic        saw_ct = 1'b0;

  axis_packet_fifo #(
    .DWIDTH(32), .TKEEPWIDTH(4), .TSTRBWIDTH(4), .TIDWIDTH(8), .TDESTWIDTH(8), .DEPTH(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tuser(s_tuser), .s_tid(s_tid), .s_tdest(s_tdest),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tkeep(m_tkeep), .m_tstrb(m_tstrb), .m_tuser(m_tuser), .m_tid(m_tid), .m_tdest(m_tdest),
    .count(count), .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [57:0] mk_beat(input logic [31:0] d, input logic l);
    return {d, l, d[3:0] ^ 4'hF, d[3:0], d[0], d[7:0] + 8'h10, d[7:0] ^ 8'hA0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic samp();
    @(negedge aclk);
  endtask

  task automatic drive(input logic [57:0] b);
    {s_tdata, s_tlast, s_tkeep, s_tstrb, s_tuser, s_tid, s_tdest} = b;
    s_tvalid = 1'b1;
    sb.push_back(b);
  endtask

  // Present a beat and hold it until the handshake edge, bounded.
  task automatic send(input logic [57:0] b);
    logic ok;
    ok = 1'b0;
    drive(b);
    for (int i = 0; i < 64; i++) begin
      samp();
      if (count > max_count) max_count = count;
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_ready_timeout", 64'(ok), 64'd1);
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      samp();
      if (count == '0 && sb.size() == 0) break;
    end
    chk({name, "_count_empty"}, 64'(count), 64'd0);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: compares every beat the DUT hands over on the coming edge.
  initial begin
    logic [57:0] exp;
    forever begin
      @(negedge aclk);
      if (!areset && m_tvalid) begin
        if (pkt_count == '0) saw_ct = 1'b1;
        if (m_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", {6'd0, m_tdata, m_tlast, m_tkeep, m_tstrb, m_tuser, m_tid, m_tdest}, 64'd0);
          end else begin
            exp = sb.pop_front();
            chk("out_beat", {6'd0, m_tdata, m_tlast, m_tkeep, m_tstrb, m_tuser, m_tid, m_tdest}, {6'd0, exp});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    samp();
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);

    // 4-beat packet, store-and-forward latency
    step();
    m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(mk_beat(32'(k), k == 4));
      samp();
      chk("sf_m_tvalid_low", 64'(m_tvalid), 64'd0);
      step();
    end
    s_tvalid = 1'b0;
    samp();
    chk("sf_m_tvalid_rise", 64'(m_tvalid), 64'd1);
    chk("sf_count", 64'(count), 64'd4);
    chk("sf_pkt_count", 64'(pkt_count), 64'd1);
    drain("sf");

    // Fill with 16 single-beat packets, then read-while-full
    step();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(mk_beat(32'(100 + i), 1'b1));
      step();
    end
    s_tvalid = 1'b0;
    samp();
    chk("full_count", 64'(count), 64'd16);
    chk("full_pkt_count", 64'(pkt_count), 64'd16);
    chk("full_s_tready", 64'(s_tready), 64'd0);
    step();
    m_tready = 1'b1;
    drive(mk_beat(32'd200, 1'b1));
    samp();
    chk("full_rd_s_tready", 64'(s_tready), 64'd0);
    step();
    m_tready = 1'b0;
    samp();
    chk("full_after_rd_count", 64'(count), 64'd15);
    chk("full_after_rd_s_tready", 64'(s_tready), 64'd1);
    step();
    s_tvalid = 1'b0;
    samp();
    chk("full_refill_count", 64'(count), 64'd16);
    chk("full_refill_pkt_count", 64'(pkt_count), 64'd16);
    step();
    m_tready = 1'b1;
    drain("full");

    // Simultaneous tlast write and tlast read
    step();
    m_tready = 1'b0;
    drive(mk_beat(32'd600, 1'b1));
    step();
    drive(mk_beat(32'd601, 1'b1));
    step();
    s_tvalid = 1'b0;
    samp();
    chk("both_pre_pkt_count", 64'(pkt_count), 64'd2);
    step();
    m_tready = 1'b1;
    drive(mk_beat(32'd602, 1'b1));
    step();
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    samp();
    chk("both_pkt_count", 64'(pkt_count), 64'd2);
    chk("both_count", 64'(count), 64'd2);
    step();
    m_tready = 1'b1;
    drain("both");

    // 20-beat oversize packet forces cut-through
    step();
    max_count = '0;
    saw_ct = 1'b0;
    for (int i = 1; i <= 20; i++) send(mk_beat(32'(300 + i), i == 20));
    drain("ct");
    chk("ct_max_count", 64'(max_count), 64'd16);
    chk("ct_seen", 64'(saw_ct), 64'd1);
    chk("ct_pkt_count", 64'(pkt_count), 64'd0);
    step();
    drive(mk_beat(32'd700, 1'b0));
    step();
    s_tvalid = 1'b0;
    samp();
    chk("ct_cleared_m_tvalid", 64'(m_tvalid), 64'd0);
    step();
    send(mk_beat(32'd701, 1'b1));
    drain("ct_after");

    // Asynchronous reset mid-packet discards the partial packet
    step();
    for (int i = 0; i < 3; i++) send(mk_beat(32'(400 + i), 1'b0));
    #2 areset = 1'b1;
    #1;
    chk("arst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("arst_s_tready", 64'(s_tready), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    sb.delete();
    step();
    areset = 1'b0;
    samp();
    chk("arst_release_s_tready", 64'(s_tready), 64'd1);
    step();
    send(mk_beat(32'd500, 1'b0));
    send(mk_beat(32'd501, 1'b1));
    drain("arst");
    chk("arst_pkt_count", 64'(pkt_count), 64'd0);

    repeat (3) samp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
